// File: rtl/branch_rs_unit.sv
// Branch reservation station: holds in-flight conditional branches, snoops the CDB,
// resolves the oldest ready branch each cycle. Define BR_RS_PERF_EN for resolve/mispredict counters.
package branch_rs_pkg;
    localparam int RS_TAG_W = 4;
    typedef logic [RS_TAG_W-1:0] rs_tag_t;
    typedef logic [31:0]         word32_t;
    localparam rs_tag_t NO_VAL = '0;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5
    } branch_op_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;
endpackage

module branch_rs_unit
    import branch_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int BR_ID_W     = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  cdb_t               cdb_i,
    input  logic               write_i,
    input  branch_op_t         branch_op_type_i,
    input  rs_tag_t            tag1_i,
    input  rs_tag_t            tag2_i,
    input  word32_t            val1_i,
    input  word32_t            val2_i,
    input  logic               br_taken_i,
    input  logic [BR_ID_W-1:0] br_id_i,
    input  logic               flush_i,
    output logic               full_o,
    output logic               resolve_valid_o,
    output logic [BR_ID_W-1:0] resolve_id_o,
    output logic               actual_taken_o,
    output logic               mispredict_o
`ifdef BR_RS_PERF_EN
    ,
    output logic [31:0]        perf_resolved_o,
    output logic [31:0]        perf_mispred_o
`endif
);
    localparam int RANK_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [RANK_W-1:0]      rank_q [NUM_ENTRIES];
    branch_op_t             op_q   [NUM_ENTRIES];
    rs_tag_t                tag1_q [NUM_ENTRIES];
    rs_tag_t                tag2_q [NUM_ENTRIES];
    word32_t                val1_q [NUM_ENTRIES];
    word32_t                val2_q [NUM_ENTRIES];
    logic                   pred_q [NUM_ENTRIES];
    logic [BR_ID_W-1:0]     id_q   [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] ready;
    logic                   sel_found;
    logic [RANK_W-1:0]      sel_idx;
    logic [RANK_W-1:0]      sel_rank;
    logic [RANK_W-1:0]      alloc_idx;
    logic [RANK_W-1:0]      num_valid;
    logic                   sel_taken;
    logic                   do_write;

    function automatic logic eval_cond(branch_op_t op, word32_t a, word32_t b);
        case (op)
            BR_BEQ:  return a == b;
            BR_BNE:  return a != b;
            BR_BLT:  return $signed(a) <  $signed(b);
            BR_BGE:  return $signed(a) >= $signed(b);
            BR_BLTU: return a <  b;
            BR_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // NOTE: every combinational output gets a default before the loop so no latch is inferred;
    // blocking assignments are correct here because the block models pure logic.
    always_comb begin
        ready     = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_rank  = '0;
        alloc_idx = '0;
        num_valid = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = RANK_W'(i);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready[i]  = valid_q[i] && (tag1_q[i] == NO_VAL) && (tag2_q[i] == NO_VAL);
            num_valid = num_valid + RANK_W'(valid_q[i]);
            if (ready[i] && (!sel_found || rank_q[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = RANK_W'(i);
                sel_rank  = rank_q[i];
            end
        end
    end

    // num_valid wraps when full, but it is only consumed when not full.
    assign full_o    = &valid_q;
    assign do_write  = write_i && !full_o && !flush_i;
    assign sel_taken = eval_cond(op_q[sel_idx], val1_q[sel_idx], val2_q[sel_idx]);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            valid_q         <= '0;
            resolve_valid_o <= 1'b0;
            resolve_id_o    <= '0;
            actual_taken_o  <= 1'b0;
            mispredict_o    <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) rank_q[i] <= '0;
        end else if (flush_i) begin
            valid_q         <= '0;
            resolve_valid_o <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) rank_q[i] <= '0;
        end else begin
            resolve_valid_o <= sel_found;
            if (sel_found) begin
                valid_q[sel_idx] <= 1'b0;
                resolve_id_o     <= id_q[sel_idx];
                actual_taken_o   <= sel_taken;
                mispredict_o     <= sel_taken != pred_q[sel_idx];
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (valid_q[i] && rank_q[i] > sel_rank) rank_q[i] <= rank_q[i] - 1'b1;
                end
            end
            if (do_write) begin
                valid_q[alloc_idx] <= 1'b1;
                rank_q[alloc_idx]  <= num_valid - RANK_W'(sel_found);
            end
        end
    end

    // NOTE: payload storage has no reset; it is only meaningful while the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && cdb_i.tag != NO_VAL) begin
                if (tag1_q[i] == cdb_i.tag) begin
                    tag1_q[i] <= NO_VAL;
                    val1_q[i] <= cdb_i.val;
                end
                if (tag2_q[i] == cdb_i.tag) begin
                    tag2_q[i] <= NO_VAL;
                    val2_q[i] <= cdb_i.val;
                end
            end
        end
        if (do_write) begin
            op_q[alloc_idx]   <= branch_op_type_i;
            pred_q[alloc_idx] <= br_taken_i;
            id_q[alloc_idx]   <= br_id_i;
            if (tag1_i != NO_VAL && tag1_i == cdb_i.tag) begin
                tag1_q[alloc_idx] <= NO_VAL;
                val1_q[alloc_idx] <= cdb_i.val;
            end else begin
                tag1_q[alloc_idx] <= tag1_i;
                val1_q[alloc_idx] <= val1_i;
            end
            if (tag2_i != NO_VAL && tag2_i == cdb_i.tag) begin
                tag2_q[alloc_idx] <= NO_VAL;
                val2_q[alloc_idx] <= cdb_i.val;
            end else begin
                tag2_q[alloc_idx] <= tag2_i;
                val2_q[alloc_idx] <= val2_i;
            end
        end
    end

`ifdef BR_RS_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            perf_resolved_o <= '0;
            perf_mispred_o  <= '0;
        end else if (!flush_i && sel_found) begin
            if (perf_resolved_o != 32'hFFFF_FFFF) perf_resolved_o <= perf_resolved_o + 32'd1;
            if (sel_taken != pred_q[sel_idx] && perf_mispred_o != 32'hFFFF_FFFF)
                perf_mispred_o <= perf_mispred_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_rs_unit.sv
// Scoreboard bench for branch_rs_unit: an age-ordered queue model predicts each resolve and its cycle.
module tb_branch_rs_unit;
    import branch_rs_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           reset_i;
    cdb_t           cdb;
    logic           write;
    branch_op_t     op_in;
    rs_tag_t        tag1, tag2;
    word32_t        val1, val2;
    logic           pred;
    logic [IDW-1:0] id;
    logic           flush;
    logic           full_o;
    logic           resolve_valid_o;
    logic [IDW-1:0] resolve_id_o;
    logic           actual_taken_o;
    logic           mispredict_o;
`ifdef BR_RS_PERF_EN
    logic [31:0]    perf_resolved_o;
    logic [31:0]    perf_mispred_o;
`endif

    branch_rs_unit #(.NUM_ENTRIES(N), .BR_ID_W(IDW)) dut (
        .clk_i(clk), .reset_i(reset_i), .cdb_i(cdb), .write_i(write),
        .branch_op_type_i(op_in), .tag1_i(tag1), .tag2_i(tag2), .val1_i(val1), .val2_i(val2),
        .br_taken_i(pred), .br_id_i(id), .flush_i(flush), .full_o(full_o),
        .resolve_valid_o(resolve_valid_o), .resolve_id_o(resolve_id_o),
        .actual_taken_o(actual_taken_o), .mispredict_o(mispredict_o)
`ifdef BR_RS_PERF_EN
        , .perf_resolved_o(perf_resolved_o), .perf_mispred_o(perf_mispred_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]     op;
        rs_tag_t        t1, t2;
        word32_t        v1, v2;
        logic           pred;
        logic [IDW-1:0] id;
    } ent_t;

    typedef struct {
        int             cyc;
        logic [IDW-1:0] id;
        logic           taken;
        logic           mis;
    } exp_t;

    ent_t model_q[$];
    exp_t sb_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic [IDW-1:0] last_id = '0;
    logic last_taken = 1'b0;
    logic last_mis = 1'b0;
    int   total_resolved = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic ref_taken(logic [2:0] op, word32_t a, word32_t b);
        int sa = int'(a);
        int sb = int'(b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return sa < sb;
            3'd3: return sa >= sb;
            3'd4: return ua < ub;
            3'd5: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: queue in age order; oldest fully-known branch resolves, then CDB snoop, then append.
    task automatic model_step();
        bit   full_before;
        ent_t e;
        cyc++;
        if (!reset_i || flush) begin
            model_q.delete();
            return;
        end
        full_before = (model_q.size() == N);
        for (int k = 0; k < model_q.size(); k++) begin
            if (model_q[k].t1 == NO_VAL && model_q[k].t2 == NO_VAL) begin
                logic t;
                t = ref_taken(model_q[k].op, model_q[k].v1, model_q[k].v2);
                sb_q.push_back('{cyc, model_q[k].id, t, t != model_q[k].pred});
                model_q.delete(k);
                break;
            end
        end
        if (cdb.tag != NO_VAL) begin
            for (int k = 0; k < model_q.size(); k++) begin
                if (model_q[k].t1 == cdb.tag) begin model_q[k].t1 = NO_VAL; model_q[k].v1 = cdb.val; end
                if (model_q[k].t2 == cdb.tag) begin model_q[k].t2 = NO_VAL; model_q[k].v2 = cdb.val; end
            end
        end
        if (write && !full_before) begin
            e = '{op_in, tag1, tag2, val1, val2, pred, id};
            if (tag1 != NO_VAL && tag1 == cdb.tag) begin e.t1 = NO_VAL; e.v1 = cdb.val; end
            if (tag2 != NO_VAL && tag2 == cdb.tag) begin e.t2 = NO_VAL; e.v2 = cdb.val; end
            model_q.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        write = 1'b0; op_in = BR_BEQ; tag1 = NO_VAL; tag2 = NO_VAL;
        val1 = '0; val2 = '0; pred = 1'b0; id = '0; flush = 1'b0; cdb = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        idle_inputs();
    endtask

    task automatic wr(logic [2:0] op, rs_tag_t t1, word32_t v1, rs_tag_t t2, word32_t v2,
                      logic p, logic [IDW-1:0] i);
        write = 1'b1; op_in = branch_op_t'(op); tag1 = t1; val1 = v1; tag2 = t2; val2 = v2;
        pred = p; id = i;
    endtask

    task automatic bcast(rs_tag_t t, word32_t v);
        cdb.tag = t;
        cdb.val = v;
    endtask

    function automatic word32_t pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("full", full_o, model_q.size() == N);
            if (resolve_valid_o) begin
                if (sb_q.size() == 0) begin
                    check("resolve_valid", resolve_valid_o, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resolve_cycle", cyc, e.cyc);
                    check("resolve_id", resolve_id_o, e.id);
                    check("actual_taken", actual_taken_o, e.taken);
                    check("mispredict", mispredict_o, e.mis);
                    last_id = e.id; last_taken = e.taken; last_mis = e.mis;
                    total_resolved++;
                end
            end else begin
                if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                    check("resolve_valid", resolve_valid_o, 1'b1);
                    void'(sb_q.pop_front());
                end
                check("hold_id", resolve_id_o, last_id);
                check("hold_taken", actual_taken_o, last_taken);
                check("hold_mis", mispredict_o, last_mis);
            end
        end
    end

    initial begin
        idle_inputs();
        reset_i = 1'b0;
        step();
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        check("rst_valid", resolve_valid_o, 1'b0);
        check("rst_id", resolve_id_o, 0);
        check("rst_taken", actual_taken_o, 1'b0);
        check("rst_mis", mispredict_o, 1'b0);
        check("rst_full", full_o, 1'b0);
        mon_en = 1'b1;

        // BLT -1 < 1, predicted taken
        wr(3'd2, NO_VAL, 32'hFFFF_FFFF, NO_VAL, 32'd1, 1'b1, 4'd3);
        step(); step();
        check("t1_valid", resolve_valid_o, 1'b1);
        check("t1_id", resolve_id_o, 4'd3);
        check("t1_taken", actual_taken_o, 1'b1);
        check("t1_mis", mispredict_o, 1'b0);
        step();

        // BNE waiting on tag 5, operand arrives later
        wr(3'd1, 4'd5, 32'd0, NO_VAL, 32'd7, 1'b0, 4'd4);
        step(); step(); step();
        bcast(4'd5, 32'd7);
        step(); step();
        check("t2_valid", resolve_valid_o, 1'b1);
        check("t2_id", resolve_id_o, 4'd4);
        check("t2_taken", actual_taken_o, 1'b0);
        step();

        // bypass at write
        wr(3'd0, 4'd6, 32'd0, NO_VAL, 32'd9, 1'b0, 4'd5);
        bcast(4'd6, 32'd9);
        step(); step();
        check("t3_valid", resolve_valid_o, 1'b1);
        check("t3_taken", actual_taken_o, 1'b1);
        check("t3_mis", mispredict_o, 1'b1);
        step();

        // fill, drop extra, resolve in age order
        for (int k = 1; k <= N; k++) begin
            wr(3'd0, rs_tag_t'(k), 32'd0, NO_VAL, 32'd2, 1'b1, 4'(7 + k));
            step();
        end
        check("t4_full", full_o, 1'b1);
        wr(3'd0, NO_VAL, 32'd0, NO_VAL, 32'd0, 1'b0, 4'd12);
        step();
        bcast(4'd4, 32'd2);
        step();
        bcast(4'd1, 32'd2);
        step();
        check("t4_first_id", resolve_id_o, 4'd11);
        step();
        check("t4_second_id", resolve_id_o, 4'd8);
        bcast(4'd2, 32'd2); step();
        bcast(4'd3, 32'd2); step();
        step(); step();

        // flush kills waiting entries, in-flight resolve and a simultaneous write
        wr(3'd0, 4'd1, 32'd0, NO_VAL, 32'd0, 1'b0, 4'd1); step();
        wr(3'd0, 4'd2, 32'd0, NO_VAL, 32'd0, 1'b0, 4'd2); step();
        wr(3'd0, NO_VAL, 32'd0, NO_VAL, 32'd0, 1'b0, 4'd3); step();
        flush = 1'b1;
        wr(3'd0, NO_VAL, 32'd0, NO_VAL, 32'd0, 1'b0, 4'd4);
        step();
        check("t5_full", full_o, 1'b0);
        check("t5_valid", resolve_valid_o, 1'b0);
        bcast(4'd1, 32'd0); step();
        bcast(4'd2, 32'd0); step();
        step(); step();

        // unsigned vs signed compare of all-ones
        wr(3'd5, NO_VAL, 32'hFFFF_FFFF, NO_VAL, 32'd1, 1'b0, 4'd1); step();
        wr(3'd3, NO_VAL, 32'hFFFF_FFFF, NO_VAL, 32'd1, 1'b0, 4'd2); step();
        check("t6_bgeu", actual_taken_o, 1'b1);
        step();
        check("t6_bge", actual_taken_o, 1'b0);
        step();

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 99) < 60) begin
                wr(3'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) == 0) ? NO_VAL : rs_tag_t'($urandom_range(1, 6)), pick_val(),
                   ($urandom_range(0, 1) == 0) ? NO_VAL : rs_tag_t'($urandom_range(1, 6)), pick_val(),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
            bcast(rs_tag_t'($urandom_range(0, 6)), pick_val());
            flush = ($urandom_range(0, 99) < 2);
            step();
        end

        for (int t = 1; t <= 6; t++) begin
            bcast(rs_tag_t'(t), 32'd0);
            step();
        end
        for (int c = 0; c < 8; c++) step();
        check("drain_sb_empty", sb_q.size(), 0);
        check("drain_model_empty", model_q.size(), 0);
`ifdef BR_RS_PERF_EN
        check("perf_resolved", perf_resolved_o, total_resolved);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
